// File: rtl/control32_mc_fsm.sv
// control32_mc_fsm: multicycle IF/ID/EXE/MEM/WB sequencer for Minisys-1A with memory handshake and exception entry.
// Optional MEM_TIMEOUT_EN raises a bus error when memory stalls for MEM_TIMEOUT cycles.
module control32_mc_fsm #(
    parameter int                   ADDR_HI_W   = 22,
    parameter logic [ADDR_HI_W-1:0] IO_PREFIX   = {ADDR_HI_W{1'b1}},
    parameter int                   WAIT_W      = 4,
    parameter int                   MEM_TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          Instruction,
    input  logic [ADDR_HI_W-1:0] Alu_resultHigh,
    input  logic                 Zero,
    input  logic                 Negative,
    input  logic                 mem_ready,
    input  logic                 irq,
    input  logic                 int_en,
    input  logic                 Reserved_instruction,
    input  logic                 Syscall,
    input  logic                 Break,
    input  logic                 Eret,
    output logic [2:0]           Wpc,
    output logic                 Wir,
    output logic                 Waluresult,
    output logic                 RegWrite_en,
    output logic                 mem_req,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IORead,
    output logic                 IOWrite,
    output logic                 Wepc,
    output logic [4:0]           Cause,
    output logic [2:0]           state_o
);
    typedef enum logic [2:0] {S_INIT, S_IF, S_ID, S_EXE, S_MEM, S_WB, S_EXC} state_t;

    state_t            st, nxt;
    logic [WAIT_W-1:0] cnt, cnt_d;
    logic [4:0]        cause_q, exc_d;

    logic [5:0] op, fn;
    logic [4:0] rt;
    assign op = Instruction[31:26];
    assign fn = Instruction[5:0];
    assign rt = Instruction[20:16];

    logic unused_bits;
    assign unused_bits = ^{Instruction[25:21], Instruction[15:6]};

    logic is_load, is_store, is_jr, is_jalr, is_j, is_jal, jump, link_j;
    logic beq, bne, blez, bgtz, bltz, bgez, bltzal, bgezal, branch, taken, io;
    assign is_load  = op[5:3] == 3'b100;
    assign is_store = op[5:2] == 4'b1010;
    assign is_jr    = op == 6'd0 && fn == 6'b001000;
    assign is_jalr  = op == 6'd0 && fn == 6'b001001;
    assign is_j     = op == 6'd2;
    assign is_jal   = op == 6'd3;
    assign jump     = is_j | is_jal | is_jr | is_jalr;
    assign link_j   = is_jal | is_jalr;
    assign beq      = op == 6'd4;
    assign bne      = op == 6'd5;
    assign blez     = op == 6'd6;
    assign bgtz     = op == 6'd7;
    assign bltz     = op == 6'd1 && rt == 5'd0;
    assign bgez     = op == 6'd1 && rt == 5'd1;
    assign bltzal   = op == 6'd1 && rt == 5'd16;
    assign bgezal   = op == 6'd1 && rt == 5'd17;
    assign branch   = beq | bne | blez | bgtz | bltz | bgez | bltzal | bgezal;
    assign taken    = (beq & Zero) | (bne & ~Zero) | ((bgez | bgezal) & ~Negative)
                    | ((bltz | bltzal) & Negative) | (bgtz & ~Negative & ~Zero)
                    | (blez & (Negative | Zero));
    assign io       = Alu_resultHigh == IO_PREFIX;

    logic tmo;
`ifdef MEM_TIMEOUT_EN
    assign tmo = cnt == WAIT_W'(MEM_TIMEOUT) && !mem_ready;
`else
    logic unused_tmo;
    assign unused_tmo = cnt == WAIT_W'(MEM_TIMEOUT);
    assign tmo = 1'b0;
`endif

    assign state_o = st;

    always_comb begin
        nxt         = st;
        exc_d       = cause_q;
        Wpc         = 3'b000;
        Wir         = 1'b0;
        Waluresult  = 1'b0;
        RegWrite_en = 1'b0;
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IORead      = 1'b0;
        IOWrite     = 1'b0;
        Wepc        = 1'b0;
        Cause       = 5'd0;
        case (st)
            S_INIT: nxt = S_IF;
            S_IF: begin
                // a zero wait count marks the first IF cycle, the only point an interrupt is taken
                if (cnt == '0 && irq && int_en) begin
                    nxt   = S_EXC;
                    exc_d = 5'd0;
                end else if (tmo) begin
                    nxt   = S_EXC;
                    exc_d = 5'd6;
                end else begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    Wir     = mem_ready;
                    Wpc     = mem_ready ? 3'b001 : 3'b000;
                    nxt     = mem_ready ? S_ID : S_IF;
                end
            end
            S_ID: begin
                if (Reserved_instruction | Syscall | Break) begin
                    nxt   = S_EXC;
                    exc_d = Reserved_instruction ? 5'd10 : Syscall ? 5'd8 : 5'd9;
                end else if (Eret) begin
                    Wpc = 3'b101;
                    nxt = S_IF;
                end else if (jump) begin
                    Wpc         = 3'b010;
                    RegWrite_en = link_j;
                    nxt         = S_IF;
                end else begin
                    nxt = S_EXE;
                end
            end
            S_EXE: begin
                Waluresult  = 1'b1;
                RegWrite_en = bltzal | bgezal;
                Wpc         = (branch && taken) ? 3'b011 : 3'b000;
                nxt         = (is_load | is_store) ? S_MEM : branch ? S_IF : S_WB;
            end
            S_MEM: begin
                if (io) begin
                    IORead  = is_load;
                    IOWrite = ~is_load;
                    nxt     = is_load ? S_WB : S_IF;
                end else if (tmo) begin
                    nxt   = S_EXC;
                    exc_d = 5'd7;
                end else begin
                    mem_req  = 1'b1;
                    MemRead  = is_load;
                    MemWrite = ~is_load;
                    nxt      = !mem_ready ? S_MEM : is_load ? S_WB : S_IF;
                end
            end
            S_WB: begin
                RegWrite_en = 1'b1;
                nxt         = S_IF;
            end
            S_EXC: begin
                Wepc  = 1'b1;
                Wpc   = 3'b100;
                Cause = cause_q;
                nxt   = S_IF;
            end
            default: nxt = S_INIT;
        endcase
        cnt_d = (nxt == st && (st == S_IF || st == S_MEM)) ? (&cnt ? cnt : cnt + 1'b1) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st      <= S_INIT;
            cnt     <= '0;
            cause_q <= 5'd0;
        end else begin
            st      <= nxt;
            cnt     <= cnt_d;
            cause_q <= exc_d;
        end
    end
endmodule

// File: tb/tb_control32_mc_fsm.sv
// tb_control32_mc_fsm: random and directed instruction flows checked cycle by cycle against a per-instruction reference.
module tb_control32_mc_fsm;
    localparam int AW = 22;
    localparam int TN = 15;
`ifdef MEM_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    localparam logic [8:0] WIR = 9'h100, WALU = 9'h080, RW = 9'h040, REQ = 9'h020, MR = 9'h010,
                           MW = 9'h008, IOR = 9'h004, IOW = 9'h002, WEPC = 9'h001;

    logic clock = 1'b0, reset_n = 1'b0;
    logic [31:0] Instruction;
    logic [AW-1:0] Alu_resultHigh;
    logic Zero, Negative, mem_ready, irq, int_en, Reserved_instruction, Syscall, Break, Eret;
    logic [2:0] Wpc, state_o;
    logic Wir, Waluresult, RegWrite_en, mem_req, MemRead, MemWrite, IORead, IOWrite, Wepc;
    logic [4:0] Cause;
    logic [19:0] outv;

    control32_mc_fsm dut (
        .clock(clock), .reset_n(reset_n), .Instruction(Instruction), .Alu_resultHigh(Alu_resultHigh),
        .Zero(Zero), .Negative(Negative), .mem_ready(mem_ready), .irq(irq), .int_en(int_en),
        .Reserved_instruction(Reserved_instruction), .Syscall(Syscall), .Break(Break), .Eret(Eret),
        .Wpc(Wpc), .Wir(Wir), .Waluresult(Waluresult), .RegWrite_en(RegWrite_en), .mem_req(mem_req),
        .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite), .Wepc(Wepc),
        .Cause(Cause), .state_o(state_o)
    );

    always #5 clock = ~clock;
    assign outv = {state_o, Wpc, Wir, Waluresult, RegWrite_en, mem_req, MemRead, MemWrite,
                   IORead, IOWrite, Wepc, Cause};

    int n_checks = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef enum int {C_ADD, C_J, C_JAL, C_JR, C_JALR, C_BEQ, C_BNE, C_BLEZ, C_BGTZ,
                      C_BLTZ, C_BGEZ, C_BLTZAL, C_BGEZAL, C_LW, C_SW} cls_t;

    function automatic logic [31:0] enc(input cls_t c);
        logic [31:0] r = $urandom;
        case (c)
            C_ADD:    return {6'd0, r[25:6], 6'b100000};
            C_J:      return {6'd2, r[25:0]};
            C_JAL:    return {6'd3, r[25:0]};
            C_JR:     return {6'd0, r[25:6], 6'b001000};
            C_JALR:   return {6'd0, r[25:6], 6'b001001};
            C_BEQ:    return {6'd4, r[25:0]};
            C_BNE:    return {6'd5, r[25:0]};
            C_BLEZ:   return {6'd6, r[25:0]};
            C_BGTZ:   return {6'd7, r[25:0]};
            C_BLTZ:   return {6'd1, r[25:21], 5'd0, r[15:0]};
            C_BGEZ:   return {6'd1, r[25:21], 5'd1, r[15:0]};
            C_BLTZAL: return {6'd1, r[25:21], 5'd16, r[15:0]};
            C_BGEZAL: return {6'd1, r[25:21], 5'd17, r[15:0]};
            C_LW:     return {6'h23, r[25:0]};
            default:  return {6'h2b, r[25:0]};
        endcase
    endfunction

    function automatic bit is_taken(input cls_t c, input bit z, input bit n);
        case (c)
            C_BEQ:            return z;
            C_BNE:            return !z;
            C_BLEZ:           return n || z;
            C_BGTZ:           return !n && !z;
            C_BLTZ, C_BLTZAL: return n;
            C_BGEZ, C_BGEZAL: return !n;
            default:          return 1'b0;
        endcase
    endfunction

    logic [19:0] exp_q[$];
    logic [1:0]  rdy_q[$];

    // rdy: 0/1 drive mem_ready that value, 2 = don't care (random)
    function automatic void push(input int st, input int wpc, input logic [8:0] f, input int cause,
                                 input logic [1:0] rdy);
        logic [2:0] s3 = 3'(st);
        logic [2:0] w3 = 3'(wpc);
        logic [4:0] c5 = 5'(cause);
        exp_q.push_back({s3, w3, f, c5});
        rdy_q.push_back(rdy);
    endfunction

    // irqm: 0 none, 1 irq+int_en at IF entry, 2 irq masked, 3 irq+int_en only after first cycle
    task automatic run_instr(input cls_t c, input int fw, input int mw, input bit z, input bit n,
                             input bit io, input logic [2:0] ex, input bit eret, input int irqm,
                             input int abort);
        logic [31:0] ins = enc(c);
        bit ld   = c == C_LW;
        bit ldst = c inside {C_LW, C_SW};
        bit jmp  = c inside {C_J, C_JAL, C_JR, C_JALR};
        bit lnk  = c inside {C_JAL, C_JALR};
        bit br   = c inside {C_BEQ, C_BNE, C_BLEZ, C_BGTZ, C_BLTZ, C_BGEZ, C_BLTZAL, C_BGEZAL};
        bit al   = c inside {C_BLTZAL, C_BGEZAL};
        logic [AW-1:0] hi = io ? '1 : (AW'($urandom) & ~AW'(1));
        exp_q.delete();
        rdy_q.delete();
        if (irqm == 1) begin
            push(1, 0, 0, 0, 1);
            push(6, 4, WEPC, 0, 2);
        end else if (TMO_ON && fw >= TN) begin
            for (int i = 0; i < TN; i++) push(1, 0, REQ | MR, 0, 0);
            push(1, 0, 0, 0, 0);
            push(6, 4, WEPC, 6, 2);
        end else begin
            for (int i = 0; i < fw; i++) push(1, 0, REQ | MR, 0, 0);
            push(1, 1, WIR | REQ | MR, 0, 1);
            if (ex != 0) begin
                push(2, 0, 0, 0, 2);
                push(6, 4, WEPC, ex[2] ? 10 : ex[1] ? 8 : 9, 2);
            end else if (eret) push(2, 5, 0, 0, 2);
            else if (jmp) push(2, 2, lnk ? RW : 9'h0, 0, 2);
            else begin
                push(2, 0, 0, 0, 2);
                if (br) push(3, is_taken(c, z, n) ? 3 : 0, WALU | (al ? RW : 9'h0), 0, 2);
                else if (ldst) begin
                    push(3, 0, WALU, 0, 2);
                    if (io) begin
                        push(4, 0, ld ? IOR : IOW, 0, 2);
                        if (ld) push(5, 0, RW, 0, 2);
                    end else if (TMO_ON && mw >= TN) begin
                        for (int i = 0; i < TN; i++) push(4, 0, REQ | (ld ? MR : MW), 0, 0);
                        push(4, 0, 0, 0, 0);
                        push(6, 4, WEPC, 7, 2);
                    end else begin
                        for (int i = 0; i < mw; i++) push(4, 0, REQ | (ld ? MR : MW), 0, 0);
                        push(4, 0, REQ | (ld ? MR : MW), 0, 1);
                        if (ld) push(5, 0, RW, 0, 2);
                    end
                end else begin
                    push(3, 0, WALU, 0, 2);
                    push(5, 0, RW, 0, 2);
                end
            end
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            Instruction = ins;
            Alu_resultHigh = hi;
            Zero = z;
            Negative = n;
            {Reserved_instruction, Syscall, Break} = ex;
            Eret = eret;
            int_en = irqm == 1 || irqm == 3;
            irq = irqm == 1 || irqm == 2 || (irqm == 3 && k > 0);
            mem_ready = rdy_q[k] == 2'd2 ? 1'($urandom) : rdy_q[k][0];
            #1 check($sformatf("%s cyc%0d", c.name(), k), {12'd0, outv}, {12'd0, exp_q[k]});
            if (k == abort) begin
                reset_n = 1'b0;
                #1 check("async_reset", {12'd0, outv}, 32'd0);
                @(negedge clock);
                check("reset_hold", {12'd0, outv}, 32'd0);
                reset_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        Instruction = 32'd0; Alu_resultHigh = '0; Zero = 0; Negative = 0; mem_ready = 1; irq = 0;
        int_en = 0; Reserved_instruction = 0; Syscall = 0; Break = 0; Eret = 0;
        repeat (2) @(negedge clock);
        #1 check("reset", {12'd0, outv}, 32'd0);
        reset_n = 1'b1;
        run_instr(C_ADD, 0, 0, 0, 0, 0, 3'b000, 0, 0, -1);
        run_instr(C_LW, 0, 3, 0, 0, 0, 3'b000, 0, 0, -1);
        run_instr(C_LW, 1, 0, 0, 0, 1, 3'b000, 0, 0, -1);
        run_instr(C_SW, 0, 2, 0, 0, 0, 3'b000, 0, 0, -1);
        run_instr(C_SW, 0, 0, 0, 0, 1, 3'b000, 0, 0, -1);
        run_instr(C_BGTZ, 0, 0, 0, 0, 0, 3'b000, 0, 0, -1);
        run_instr(C_BGTZ, 0, 0, 1, 0, 0, 3'b000, 0, 0, -1);
        run_instr(C_BLTZAL, 0, 0, 0, 0, 0, 3'b000, 0, 0, -1);
        run_instr(C_JAL, 0, 0, 0, 0, 0, 3'b000, 0, 0, -1);
        run_instr(C_ADD, 0, 0, 0, 0, 0, 3'b100, 0, 0, -1);
        run_instr(C_ADD, 0, 0, 0, 0, 0, 3'b011, 0, 0, -1);
        run_instr(C_ADD, 0, 0, 0, 0, 0, 3'b000, 1, 0, -1);
        run_instr(C_ADD, 0, 0, 0, 0, 0, 3'b000, 0, 1, -1);
        run_instr(C_ADD, 0, 0, 0, 0, 0, 3'b000, 0, 2, -1);
        run_instr(C_LW, 2, 1, 0, 0, 0, 3'b000, 0, 3, -1);
        run_instr(C_LW, 0, 3, 0, 0, 0, 3'b000, 0, 0, 4);
        run_instr(C_ADD, 1, 0, 0, 0, 0, 3'b000, 0, 0, -1);
`ifdef MEM_TIMEOUT_EN
        run_instr(C_SW, 0, 20, 0, 0, 0, 3'b000, 0, 0, -1);
        run_instr(C_ADD, 20, 0, 0, 0, 0, 3'b000, 0, 0, -1);
`endif
        for (int i = 0; i < 300; i++) begin
            logic [2:0] ex = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            run_instr(cls_t'($urandom_range(0, 14)), $urandom_range(0, 3), $urandom_range(0, 4),
                      1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, ex,
                      ex == 0 && $urandom_range(0, 9) == 0,
                      $urandom_range(0, 5) < 4 ? 0 : $urandom_range(1, 3), -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
